// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg
// Shared definitions for the accumulator-processor sequencer:
//    - opcode constants (instr[7:4])
//    - ALU unit-select encodings driven on unit_sel_out
//    - sequencer state encoding
package ctrl_seq_pkg;

   // Opcodes
   localparam logic [3:0] OPC_ADD  = 4'h0;
   localparam logic [3:0] OPC_SUB  = 4'h1;
   localparam logic [3:0] OPC_AND  = 4'h2;
   localparam logic [3:0] OPC_NAND = 4'h3;
   localparam logic [3:0] OPC_SLL  = 4'h4;
   localparam logic [3:0] OPC_SRL  = 4'h5;
   localparam logic [3:0] OPC_LD   = 4'h6;
   localparam logic [3:0] OPC_OR   = 4'h7;
   localparam logic [3:0] OPC_XOR  = 4'h8;
   localparam logic [3:0] OPC_ST   = 4'h9;
   localparam logic [3:0] OPC_LDI  = 4'hA;
   localparam logic [3:0] OPC_BNEZ = 4'hB;
   localparam logic [3:0] OPC_NOP  = 4'hC;
   localparam logic [3:0] OPC_HALT = 4'hF;

   // ALU unit selects
   localparam logic [2:0] UNIT_ADD   = 3'b000;
   localparam logic [2:0] UNIT_AND   = 3'b001;
   localparam logic [2:0] UNIT_SHIFT = 3'b010;
   localparam logic [2:0] UNIT_PASS  = 3'b011;
   localparam logic [2:0] UNIT_OR    = 3'b100;
   localparam logic [2:0] UNIT_XOR   = 3'b101;
   localparam logic [2:0] UNIT_ACC   = 3'b111;

   // Sequencer states
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_e;

endpackage

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if
// Bundles the instruction-fetch handshake and the ALU control bus.
//    master (sequencer): drives fetch request/PC, ALU selects, strobes, halted
//    slave  (memory/ALU): drives instruction byte/valid and ALU result
interface ctrl_seq_if #(
   parameter int PC_W  = 8,
   parameter int RF_AW = 4
);

   logic             instr_req_out;
   logic [PC_W-1:0]  pc_out;
   logic             instr_valid_in;
   logic [7:0]       instr_in;
   logic [2:0]       unit_sel_out;
   logic             op_sel_out;
   logic             imm_sel_out;
   logic [RF_AW-1:0] rf_addr_out;
   logic             acc_we_out;
   logic             rf_we_out;
   logic [7:0]       alu_res_in;
   logic             halted_out;

   modport master (
      output instr_req_out, pc_out, unit_sel_out, op_sel_out, imm_sel_out,
             rf_addr_out, acc_we_out, rf_we_out, halted_out,
      input  instr_valid_in, instr_in, alu_res_in
   );

   modport slave (
      input  instr_req_out, pc_out, unit_sel_out, op_sel_out, imm_sel_out,
             rf_addr_out, acc_we_out, rf_we_out, halted_out,
      output instr_valid_in, instr_in, alu_res_in
   );

endinterface

// File: rtl/ctrl_seq_decode.sv
// ctrl_decode
// Purely combinational opcode decoder.
//    opc_i      : instruction opcode (instr[7:4])
//    unit_sel_o : ALU unit select
//    op_sel_o   : ALU op select within the unit
//    imm_sel_o  : 1 selects the zero-extended immediate as ALU source
//    acc_we_o   : instruction writes the accumulator
//    rf_we_o    : instruction stores the accumulator to the register file
//    is_bnez_o  : branch-if-not-zero
//    is_halt_o  : halt
module ctrl_decode
   import ctrl_seq_pkg::*;
(
   input  logic [3:0] opc_i,
   output logic [2:0] unit_sel_o,
   output logic       op_sel_o,
   output logic       imm_sel_o,
   output logic       acc_we_o,
   output logic       rf_we_o,
   output logic       is_bnez_o,
   output logic       is_halt_o
);

   // Defaults describe a NOP; each opcode only overrides what differs.
   always_comb begin
      unit_sel_o = UNIT_ACC;
      op_sel_o   = 1'b0;
      imm_sel_o  = 1'b0;
      acc_we_o   = 1'b0;
      rf_we_o    = 1'b0;
      is_bnez_o  = 1'b0;
      is_halt_o  = 1'b0;
      case (opc_i)
         OPC_ADD:  begin unit_sel_o = UNIT_ADD;   acc_we_o = 1'b1; end
         OPC_SUB:  begin unit_sel_o = UNIT_ADD;   op_sel_o = 1'b1; acc_we_o = 1'b1; end
         OPC_AND:  begin unit_sel_o = UNIT_AND;   acc_we_o = 1'b1; end
         OPC_NAND: begin unit_sel_o = UNIT_AND;   op_sel_o = 1'b1; acc_we_o = 1'b1; end
         OPC_SLL:  begin unit_sel_o = UNIT_SHIFT; acc_we_o = 1'b1; end
         OPC_SRL:  begin unit_sel_o = UNIT_SHIFT; op_sel_o = 1'b1; acc_we_o = 1'b1; end
         OPC_LD:   begin unit_sel_o = UNIT_PASS;  acc_we_o = 1'b1; end
         OPC_OR:   begin unit_sel_o = UNIT_OR;    acc_we_o = 1'b1; end
         OPC_XOR:  begin unit_sel_o = UNIT_XOR;   acc_we_o = 1'b1; end
         OPC_ST:   begin rf_we_o = 1'b1; end
         OPC_LDI:  begin unit_sel_o = UNIT_PASS;  imm_sel_o = 1'b1; acc_we_o = 1'b1; end
         OPC_BNEZ: begin is_bnez_o = 1'b1; end
         OPC_HALT: begin is_halt_o = 1'b1; end
         default:  begin end
      endcase
   end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq
// Fetch/decode/execute sequencer for the tiny accumulator processor.
//    clk, rst_n : clock and asynchronous active-low reset
//    start_in   : one-cycle pulse, starts execution at pc 0 (IDLE only)
//    bus        : master side of ctrl_seq_if (fetch handshake, ALU control,
//                 write strobes, ALU result for BNEZ, halted flag)
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int PC_W  = 8,
   parameter int RF_AW = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_in,
   ctrl_seq_if.master  bus
);

   state_e           state_q;
   logic [PC_W-1:0]  pc_q;
   logic [PC_W-1:0]  pc_d;
   logic [7:0]       ir_q;
   logic             instrReq_q;
   logic [2:0]       unitSel_q;
   logic             opSel_q;
   logic             immSel_q;
   logic [RF_AW-1:0] rfAddr_q;
   logic             accWe_q;
   logic             rfWe_q;
   logic             halted_q;

   logic [2:0]       decUnitSel;
   logic             decOpSel;
   logic             decImmSel;
   logic             decAccWe;
   logic             decRfWe;
   logic             decIsBnez;
   logic             decIsHalt;

   // The decoder looks at the latched IR, which stays put through DECODE and
   // EXEC, so the BNEZ decision in EXEC can reuse the same decode result.
   ctrl_decode uDecode (
      .opc_i      (ir_q[7:4]),
      .unit_sel_o (decUnitSel),
      .op_sel_o   (decOpSel),
      .imm_sel_o  (decImmSel),
      .acc_we_o   (decAccWe),
      .rf_we_o    (decRfWe),
      .is_bnez_o  (decIsBnez),
      .is_halt_o  (decIsHalt)
   );

   // Next PC after EXEC: a taken BNEZ adds the sign-extended 4-bit argument,
   // everything else steps by one. Both wrap naturally at 2^PC_W.
   always_comb begin
      pc_d = pc_q + PC_W'(1);
      if (decIsBnez && (bus.alu_res_in != 8'h00)) begin
         pc_d = pc_q + {{(PC_W-4){ir_q[3]}}, ir_q[3:0]};
      end
   end

   // Single sequencer process. Every output is a flop, so the write strobes
   // are set on the DECODE->EXEC edge and cleared on the EXEC->FETCH edge,
   // and reset clears them directly without any combinational path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         ir_q       <= '0;
         instrReq_q <= 1'b0;
         unitSel_q  <= 3'b000;
         opSel_q    <= 1'b0;
         immSel_q   <= 1'b0;
         rfAddr_q   <= '0;
         accWe_q    <= 1'b0;
         rfWe_q     <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_in) begin
                  pc_q       <= '0;
                  instrReq_q <= 1'b1;
                  state_q    <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (bus.instr_valid_in) begin
                  ir_q       <= bus.instr_in;
                  instrReq_q <= 1'b0;
                  state_q    <= S_DECODE;
               end
            end
            S_DECODE: begin
               // HALT leaves the control fields at their previous values.
               if (decIsHalt) begin
                  halted_q <= 1'b1;
                  state_q  <= S_HALT;
               end else begin
                  unitSel_q <= decUnitSel;
                  opSel_q   <= decOpSel;
                  immSel_q  <= decImmSel;
                  rfAddr_q  <= ir_q[RF_AW-1:0];
                  accWe_q   <= decAccWe;
                  rfWe_q    <= decRfWe;
                  state_q   <= S_EXEC;
               end
            end
            S_EXEC: begin
               accWe_q    <= 1'b0;
               rfWe_q     <= 1'b0;
               pc_q       <= pc_d;
               instrReq_q <= 1'b1;
               state_q    <= S_FETCH;
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.instr_req_out = instrReq_q;
   assign bus.pc_out        = pc_q;
   assign bus.unit_sel_out  = unitSel_q;
   assign bus.op_sel_out    = opSel_q;
   assign bus.imm_sel_out   = immSel_q;
   assign bus.rf_addr_out   = rfAddr_q;
   assign bus.acc_we_out    = accWe_q;
   assign bus.rf_we_out     = rfWe_q;
   assign bus.halted_out    = halted_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq
// Directed self-checking bench for ctrl_seq. Expected EXEC-cycle control
// values and the following PC come from an independent opcode table below;
// they are queued when an instruction is offered and popped in its EXEC cycle.
module tb_ctrl_seq;

   typedef struct packed {
      logic [2:0] unitSel;
      logic       opSel;
      logic       immSel;
      logic [3:0] rfAddr;
      logic       accWe;
      logic       rfWe;
      logic [7:0] pcNext;
   } exp_t;

   logic clk;
   logic rstN;
   logic start;

   int   checks;
   int   errors;
   logic [7:0] pcModel;
   exp_t expQ[$];
   exp_t lastExp;

   ctrl_seq_if #(.PC_W(8), .RF_AW(4)) bus ();

   ctrl_seq #(.PC_W(8), .RF_AW(4)) dut (
      .clk      (clk),
      .rst_n    (rstN),
      .start_in (start),
      .bus      (bus.master)
   );

   // Free-running 10-time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference opcode table written straight from the instruction map
   function automatic exp_t expOf(input logic [7:0] ins);
      exp_t e;
      e.unitSel = 3'b111;
      e.opSel   = 1'b0;
      e.immSel  = 1'b0;
      e.rfAddr  = ins[3:0];
      e.accWe   = 1'b0;
      e.rfWe    = 1'b0;
      e.pcNext  = 8'h00;
      case (ins[7:4])
         4'h0: begin e.unitSel = 3'b000; e.accWe = 1'b1; end
         4'h1: begin e.unitSel = 3'b000; e.opSel = 1'b1; e.accWe = 1'b1; end
         4'h2: begin e.unitSel = 3'b001; e.accWe = 1'b1; end
         4'h3: begin e.unitSel = 3'b001; e.opSel = 1'b1; e.accWe = 1'b1; end
         4'h4: begin e.unitSel = 3'b010; e.accWe = 1'b1; end
         4'h5: begin e.unitSel = 3'b010; e.opSel = 1'b1; e.accWe = 1'b1; end
         4'h6: begin e.unitSel = 3'b011; e.accWe = 1'b1; end
         4'h7: begin e.unitSel = 3'b100; e.accWe = 1'b1; end
         4'h8: begin e.unitSel = 3'b101; e.accWe = 1'b1; end
         4'h9: begin e.rfWe = 1'b1; end
         4'hA: begin e.unitSel = 3'b011; e.immSel = 1'b1; e.accWe = 1'b1; end
         default: begin end
      endcase
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkIdleStrobes(input string tag);
      checkOutput({tag, ".accWe"}, 32'(bus.acc_we_out), 32'd0);
      checkOutput({tag, ".rfWe"},  32'(bus.rf_we_out),  32'd0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, ".req"},    32'(bus.instr_req_out), 32'd0);
      checkOutput({tag, ".pc"},     32'(bus.pc_out),        32'd0);
      checkOutput({tag, ".unit"},   32'(bus.unit_sel_out),  32'd0);
      checkOutput({tag, ".op"},     32'(bus.op_sel_out),    32'd0);
      checkOutput({tag, ".imm"},    32'(bus.imm_sel_out),   32'd0);
      checkOutput({tag, ".rfAddr"}, 32'(bus.rf_addr_out),   32'd0);
      checkOutput({tag, ".halted"}, 32'(bus.halted_out),    32'd0);
      checkIdleStrobes(tag);
   endtask

   // Wait (bounded) for the fetch request; an expired budget is a failure.
   task automatic waitFetch(input string tag);
      int n = 0;
      while (bus.instr_req_out !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, ".fetchReq"}, 32'(bus.instr_req_out), 32'd1);
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer one instruction in FETCH and follow it through DECODE and EXEC
   // back to the next FETCH. Entered and left on a negedge.
   task automatic applyStimulus(input logic [7:0] ins, input logic [7:0] aluRes);
      exp_t e;
      string tag;
      tag = $sformatf("ins%02h@pc%02h", ins, pcModel);
      waitFetch(tag);
      checkOutput({tag, ".pc"}, 32'(bus.pc_out), 32'(pcModel));
      e = expOf(ins);
      if (ins[7:4] == 4'hB && aluRes != 8'h00) begin
         e.pcNext = pcModel + {{4{ins[3]}}, ins[3:0]};
      end else begin
         e.pcNext = pcModel + 8'd1;
      end
      expQ.push_back(e);
      bus.instr_in       = ins;
      bus.instr_valid_in = 1'b1;
      @(negedge clk);
      bus.instr_valid_in = 1'b0;
      bus.alu_res_in     = aluRes;
      checkIdleStrobes({tag, ".decode"});
      checkOutput({tag, ".decodeReq"}, 32'(bus.instr_req_out), 32'd0);
      @(negedge clk);
      e = expQ.pop_front();
      checkOutput({tag, ".unit"},   32'(bus.unit_sel_out), 32'(e.unitSel));
      checkOutput({tag, ".op"},     32'(bus.op_sel_out),   32'(e.opSel));
      checkOutput({tag, ".imm"},    32'(bus.imm_sel_out),  32'(e.immSel));
      checkOutput({tag, ".rfAddr"}, 32'(bus.rf_addr_out),  32'(e.rfAddr));
      checkOutput({tag, ".accWe"},  32'(bus.acc_we_out),   32'(e.accWe));
      checkOutput({tag, ".rfWe"},   32'(bus.rf_we_out),    32'(e.rfWe));
      @(negedge clk);
      checkIdleStrobes({tag, ".after"});
      checkOutput({tag, ".nextReq"},  32'(bus.instr_req_out), 32'd1);
      checkOutput({tag, ".nextPc"},   32'(bus.pc_out),        32'(e.pcNext));
      checkOutput({tag, ".holdUnit"}, 32'(bus.unit_sel_out),  32'(e.unitSel));
      pcModel = e.pcNext;
      lastExp = e;
   endtask

   // Directed test sequence
   initial begin
      checks = 0;
      errors = 0;
      pcModel = 8'h00;
      lastExp = '0;
      rstN = 1'b0;
      start = 1'b0;
      bus.instr_valid_in = 1'b0;
      bus.instr_in = 8'h00;
      bus.alu_res_in = 8'h00;

      $display("[TB] reset values");
      repeat (2) @(negedge clk);
      checkResetOutputs("reset");
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("idleReq", 32'(bus.instr_req_out), 32'd0);

      $display("[TB] LDI after start");
      pulseStart();
      applyStimulus(8'hA5, 8'h00);

      $display("[TB] ALU/store program");
      applyStimulus(8'h02, 8'h00);
      applyStimulus(8'h13, 8'h00);
      applyStimulus(8'h31, 8'h00);
      applyStimulus(8'h54, 8'h00);
      applyStimulus(8'h97, 8'h00);

      $display("[TB] BNEZ cases");
      applyStimulus(8'hBE, 8'h01);
      applyStimulus(8'hC0, 8'h00);
      applyStimulus(8'hBE, 8'h01);
      applyStimulus(8'hD0, 8'h00);
      applyStimulus(8'hE0, 8'h00);
      applyStimulus(8'hBE, 8'h00);
      applyStimulus(8'hB8, 8'h80);
      applyStimulus(8'hB7, 8'h01);

      $display("[TB] fetch stall");
      for (int i = 0; i < 4; i++) begin
         if (i == 1) start = 1'b1;
         if (i == 2) start = 1'b0;
         checkOutput("stallReq", 32'(bus.instr_req_out), 32'd1);
         checkOutput("stallPc",  32'(bus.pc_out),        32'(pcModel));
         checkIdleStrobes("stall");
         @(negedge clk);
      end
      applyStimulus(8'h84, 8'h00);
      applyStimulus(8'h76, 8'h00);
      applyStimulus(8'h45, 8'h00);
      applyStimulus(8'h6A, 8'h00);
      applyStimulus(8'h23, 8'h00);

      $display("[TB] reset during EXEC");
      waitFetch("rstExec");
      bus.instr_in       = 8'hA3;
      bus.instr_valid_in = 1'b1;
      @(negedge clk);
      bus.instr_valid_in = 1'b0;
      @(negedge clk);
      checkOutput("rstExec.accWeBefore", 32'(bus.acc_we_out), 32'd1);
      rstN = 1'b0;
      #1;
      checkResetOutputs("rstExec");
      @(negedge clk);
      rstN = 1'b1;
      pcModel = 8'h00;
      @(negedge clk);
      pulseStart();
      applyStimulus(8'h01, 8'h00);

      $display("[TB] HALT");
      waitFetch("halt");
      bus.instr_in       = 8'hF0;
      bus.instr_valid_in = 1'b1;
      @(negedge clk);
      bus.instr_valid_in = 1'b0;
      checkOutput("halt.decodeHalted", 32'(bus.halted_out), 32'd0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         start = (i == 1);
         checkOutput("halt.halted", 32'(bus.halted_out),    32'd1);
         checkOutput("halt.req",    32'(bus.instr_req_out), 32'd0);
         checkOutput("halt.pc",     32'(bus.pc_out),        32'(pcModel));
         checkOutput("halt.unit",   32'(bus.unit_sel_out),  32'(lastExp.unitSel));
         checkOutput("halt.rfAddr", 32'(bus.rf_addr_out),   32'(lastExp.rfAddr));
         checkIdleStrobes("halt");
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
Fetch/decode/execute sequencer for the tiny accumulator processor. It is the producer side of the ALU control interface.
- Fetches 8-bit instructions over a req/valid handshake.
- Decodes each instruction into the ALU unit/op selects, source select, register-file address and write strobes.
- Evaluates BNEZ against the ALU result and advances the PC.

Parameters:
PC_W, 8, program counter width in bits
RF_AW, 4, register-file address width; fixed at the operand-field width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start_in  input  1  one-cycle pulse that starts execution from pc 0 (IDLE only)
instr_req_out  output  1  fetch request; high in FETCH
pc_out  output  PC_W  fetch address / current PC
instr_valid_in  input  1  instruction byte valid; accepted only while instr_req_out=1
instr_in  input  8  instruction byte
unit_sel_out  output  3  ALU unit select
op_sel_out  output  1  ALU op select
imm_sel_out  output  1  1: ALU src is zero-extended instr[3:0]; 0: src is rf[rf_addr_out]
rf_addr_out  output  RF_AW  register-file address (instr[3:0])
acc_we_out  output  1  accumulator write strobe, one cycle in EXEC
rf_we_out  output  1  rf[rf_addr_out] <= acc, one cycle in EXEC
alu_res_in  input  8  ALU result; used only for the BNEZ decision
halted_out  output  1  high in HALT

Behaviour:
- Instruction format: opc = instr[7:4], arg = instr[3:0].
- Opcode map (opc: unit/op, acc_we, rf_we, imm_sel):
  - 0 ADD: 000/0, 1, 0, 0
  - 1 SUB: 000/1, 1, 0, 0
  - 2 AND: 001/0, 1, 0, 0
  - 3 NAND: 001/1, 1, 0, 0
  - 4 SLL: 010/0, 1, 0, 0
  - 5 SRL: 010/1, 1, 0, 0
  - 6 LD: 011/0, 1, 0, 0
  - 7 OR: 100/0, 1, 0, 0
  - 8 XOR: 101/0, 1, 0, 0
  - 9 ST: 111/0, 0, 1, 0
  - A LDI: 011/0, 1, 0, 1
  - B BNEZ: 111/0, 0, 0, 0
  - C-E NOP: 111/0, 0, 0, 0
  - F HALT.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
  - IDLE: start_in=1 -> FETCH, pc <= 0.
  - FETCH: instr_req_out=1. instr_valid_in=1 -> latch IR, go to DECODE. Otherwise hold; no timeout.
  - DECODE: register all decoded control fields. HALT opcode -> HALT; otherwise -> EXEC.
  - EXEC: control outputs valid and stable for exactly this one cycle; acc_we_out/rf_we_out pulse here only. Next state FETCH.
  - HALT: halted_out=1; all strobes 0. Stays in HALT until reset; start_in is ignored.
- Control outputs (unit_sel_out, op_sel_out, imm_sel_out, rf_addr_out) are registered. They hold their last value outside EXEC.
- Strobes: acc_we_out and rf_we_out are 0 in every state other than EXEC.
- PC update at the end of EXEC:
  - BNEZ with alu_res_in != 0: pc <= pc + sign_extend(arg). Modulo 2^PC_W wrap; arg=0 is a self-loop.
  - All other cases: pc <= pc + 1, wrapping from 2^PC_W-1 to 0.
- Throughput: 3 cycles per instruction when instr_valid_in is already high in FETCH.
- instr_valid_in outside FETCH is ignored.
- start_in outside IDLE is ignored.
- Reset (asynchronous, any state including mid-fetch or EXEC):
  - state = IDLE, pc = 0, IR = 0.
  - unit_sel_out = 000, op_sel_out = 0, imm_sel_out = 0, rf_addr_out = 0.
  - instr_req_out = 0, acc_we_out = 0, rf_we_out = 0, halted_out = 0.
  - No partial write strobe may glitch out.

Decomposition:
- Shared package holds:
  - opcode constants OPC_ADD..OPC_HALT;
  - ALU unit-select constants UNIT_ADD=000, UNIT_AND=001, UNIT_SHIFT=010, UNIT_PASS=011, UNIT_OR=100, UNIT_XOR=101, UNIT_ACC=111;
  - state encoding constants.
- One combinational sub-module, ctrl_decode: opc -> {unit_sel, op_sel, imm_sel, acc_we, rf_we, is_bnez, is_halt}. It is reusable by the bench's reference model.

Test Plan:
1. Reset, then start_in pulse, ROM returns 0xA5 with valid immediate -> fetch at pc 0; EXEC on cycle 3 with unit=011, imm_sel=1, acc_we=1; pc=1 after EXEC.
2. Program ADD r2, SUB r3, NAND r1, SRL r4, ST r7 -> each EXEC shows (000,0), (000,1), (001,1), (010,1), (111,0) with rf_addr 2/3/1/4/7. ST asserts rf_we only; ADD/SUB/NAND/SRL assert acc_we only.
3. BNEZ 0xBE at pc 5:
   - alu_res_in=0x01 -> pc=3 (5-2).
   - alu_res_in=0x00 -> pc=6.
   - BNEZ 0xB7 at pc 0xFE with nonzero result -> pc=0x05 (wrap).
4. Hold instr_valid_in low 4 cycles in FETCH -> instr_req_out stays 1, pc stable, no strobes. Valid on the 5th cycle -> normal DECODE/EXEC.
5. HALT 0xF0 -> halted_out=1 two cycles after accept; no EXEC strobe; start_in pulses ignored; instr_req_out=0.
6. Assert rst_n low during EXEC of LDI -> acc_we_out drops immediately, all outputs at reset values. Restart fetches from pc 0.
